// File: rtl/mini_sched_pkg.sv
// Shared types and constants for the mini round-robin scheduler.
package mini_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int OP_W  = 3;
  localparam int RES_W = 2;

  // Requester id width; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mini_rr_arb.sv
// Rotating-priority picker: first asserted req at or after ptr, wrapping mod N_REQ.
module mini_rr_arb
  import mini_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  always_comb begin
    int s;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    s         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(ptr) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!grant_any && req[s]) begin
        grant[s]  = 1'b1;
        grant_idx = s[ID_W-1:0];
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mini_rr_sched.sv
// Round-robin scheduler sharing one registered datapath among N_REQ requesters.
// Optional per-requester saturating grant counters under `MINI_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | no issuing, tag pipe empty
// RUN   | arbitrating and issuing one grant per cycle
// DRAIN | en low; no issuing, waiting for in-flight tags to return
module mini_rr_sched
  import mini_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT   = 2
`ifdef MINI_SCHED_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [OP_W*N_REQ-1:0]   req_x,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    dp_x1,
  output logic                    dp_x2,
  output logic                    dp_x3,
  input  logic                    dp_y1,
  input  logic                    dp_y2,
  output logic                    rsp_valid,
  output logic [id_w(N_REQ)-1:0]  rsp_id,
  output logic [RES_W-1:0]        rsp_y,
  output logic                    busy
`ifdef MINI_SCHED_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt
`endif
);

  localparam int ID_W = id_w(N_REQ);

  state_t            state, state_nxt;
  logic              run;
  logic [ID_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   grant_idx;
  logic              arb_any;
  logic              grant;
  logic [OP_W-1:0]   x_sel;
  logic              tag_v  [LAT];
  logic [ID_W-1:0]   tag_id [LAT];
  logic              pipe_busy;

  mini_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (grant_idx),
    .grant_any (arb_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)              state_nxt = RUN;
        else if (!pipe_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run  = (state == RUN);
    busy = (state != IDLE) || pipe_busy;
  end

  assign grant     = run && arb_any;
  assign req_ready = run ? arb_grant : '0;

  always_comb begin
    x_sel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (req_ready[i]) x_sel = req_x[OP_W*i +: OP_W];
  end

  assign dp_x1 = x_sel[0];
  assign dp_x2 = x_sel[1];
  assign dp_x3 = x_sel[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Tag pipe mirrors the datapath latency so ids line up with dp_y*.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= grant;
      tag_id[0] <= grant ? grant_idx : '0;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < LAT; i++) pipe_busy = pipe_busy | tag_v[i];
  end

  assign rsp_valid = tag_v[LAT-1];
  assign rsp_id    = tag_id[LAT-1];
  assign rsp_y     = rsp_valid ? {dp_y2, dp_y1} : '0;

`ifdef MINI_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt [N_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_ready[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) grant_cnt[CNT_W*i +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_mini_rr_sched.sv
// Directed self-checking bench for mini_rr_sched with a 2-stage datapath model.
// Build with MINI_SCHED_STATS_EN to include the grant counter check.
module tb_mini_rr_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [11:0] req_x;
  logic [3:0]  req_ready;
  logic        dp_x1, dp_x2, dp_x3;
  logic        dp_y1, dp_y2;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [1:0]  rsp_y;
  logic        busy;
`ifdef MINI_SCHED_STATS_EN
  logic [7:0]  grant_cnt;
`endif

  logic [2:0]  xv [4];
  logic [1:0]  y_a, y_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always_comb req_x = {xv[3], xv[2], xv[1], xv[0]};

  mini_rr_sched #(
    .N_REQ(4),
    .LAT  (2)
`ifdef MINI_SCHED_STATS_EN
    ,
    .CNT_W(2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .dp_x1     (dp_x1),
    .dp_x2     (dp_x2),
    .dp_x3     (dp_x3),
    .dp_y1     (dp_y1),
    .dp_y2     (dp_y2),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .busy      (busy)
`ifdef MINI_SCHED_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // Datapath model: y1 = x1 & x2, y2 = x2 ^ x3, two register stages.
  function automatic logic [1:0] f_y(input logic [2:0] x);
    return {x[1] ^ x[2], x[0] & x[1]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_a <= '0;
      y_b <= '0;
    end else begin
      y_a <= f_y({dp_x3, dp_x2, dp_x1});
      y_b <= y_a;
    end
  end
  assign dp_y1 = y_b[0];
  assign dp_y2 = y_b[1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] e_oh;
    int         k;
    int         rsp_n;
    int         exp_ids [3];
    bit         idle_seen;

    exp_ids = '{3, 0, 1};
    xv[0] = 3'b001; xv[1] = 3'b011; xv[2] = 3'b111; xv[3] = 3'b110;

    // 1: reset held with en=1 and all requests valid
    reset = 1'b1; en = 1'b1; req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_y", 32'(rsp_y), 32'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("idle_no_grant", 32'(req_ready), 32'h0);
    tick();

    // 2: all valid -> 0,1,2,3,... with responses two cycles later
    for (int c = 0; c < 8; c++) begin
      e_oh = 4'b0001 << (c % 4);
      chk("rr_ready", 32'(req_ready), 32'(e_oh));
      chk("rr_dp_x", 32'({dp_x3, dp_x2, dp_x1}), 32'(xv[c % 4]));
      if (c >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
        chk("rr_rsp_y", 32'(rsp_y), 32'(f_y(xv[(c - 2) % 4])));
      end else begin
        chk("rr_rsp_idle", 32'(rsp_valid), 32'h0);
      end
      tick();
    end

    // 3: only requester 2 valid
    req_valid = 4'b0100; xv[2] = 3'b011;
    #1;
    for (int c = 0; c < 6; c++) begin
      chk("solo_ready", 32'(req_ready), 32'h4);
      if (c >= 2) begin
        chk("solo_rsp_id", 32'(rsp_id), 32'h2);
        chk("solo_rsp_y11", 32'(rsp_y), 32'h3);
      end
      tick();
    end
    xv[2] = 3'b001;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (c >= 2) begin
        chk("solo_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("solo_rsp_y00", 32'(rsp_y), 32'h0);
      end
      tick();
    end

    // 4: rr_ptr=3 after grants to 2; only req 1 -> grant 1, then ptr=2
    req_valid = 4'b0010;
    #1;
    chk("wrap_grant1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("wrap_ptr2", 32'(req_ready), 32'h4);
    tick();

    // 5: three grants then en drops in the third grant cycle
    req_valid = 4'b0000;
    tick(); tick(); tick();
    chk("pre_drain_busy", 32'(busy), 32'h1);
    chk("pre_drain_rsp", 32'(rsp_valid), 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("drain_g0", 32'(req_ready), 32'h8);
    tick();
    chk("drain_g1", 32'(req_ready), 32'h1);
    tick();
    en = 1'b0;
    #1;
    chk("drain_g2", 32'(req_ready), 32'h2);
    rsp_n = 0;
    idle_seen = 1'b0;
    k = 0;
    while (!idle_seen && k < 12) begin
      if (rsp_valid) begin
        if (rsp_n < 3) chk("drain_rsp_id", 32'(rsp_id), 32'(exp_ids[rsp_n]));
        rsp_n++;
      end
      if (k == 1) chk("drain_busy_mid", 32'(busy), 32'h1);
      tick();
      k++;
      if (req_ready != 4'b0000) chk("drain_no_grant", 32'(req_ready), 32'h0);
      if (!busy) idle_seen = 1'b1;
    end
    chk("drain_idle_reached", 32'(idle_seen), 32'h1);
    chk("drain_rsp_count", 32'(rsp_n), 32'd3);
    chk("drain_final_rsp", 32'(rsp_valid), 32'h0);
    tick();
    chk("idle_stays", 32'(busy), 32'h0);

    // Reset mid-operation drops in-flight tags
    en = 1'b1;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_rsp", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_rsp", 32'(rsp_valid), 32'h0);
    chk("post_rst_grant0", 32'(req_ready), 32'h1);

`ifdef MINI_SCHED_STATS_EN
    // 6: CNT_W=2, five grants to req 0 saturate at 3
    reset = 1'b1;
    tick();
    reset = 1'b0; req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) tick();
    chk("cnt_sat0", 32'(grant_cnt[1:0]), 32'h3);
    chk("cnt_others", 32'(grant_cnt[7:2]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
